// File: rtl/uart_reg_cmd.sv
// uart_reg_cmd: ASCII command interpreter between a uart byte interface and a
// bank of output bits; every command is answered with a byte or hex string.
module uart_reg_cmd #(
    parameter int NOut     = 8,
    parameter int TimeoutW = 24
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_ready,
    input  logic            rx_err,
    output logic [7:0]      tx_data,
    output logic            tx_send,
    input  logic            tx_busy,
    output logic [NOut-1:0] out,
    output logic            err,
    output logic [7:0]      errcnt
);
    // state | meaning
    // IDLE  | waiting for a command byte
    // ARG   | s/c/t received, waiting for the bit-index digit
    // WDATA | w received, collecting ND hex digits
    // SEND  | tx_send high, waiting for tx_busy to be seen
    // DRAIN | waiting for tx_busy to fall, then next query digit or IDLE
    localparam int ND = (NOut + 3) / 4;
    localparam int SW = 4 * ND;

    typedef enum logic [2:0] {IDLE, ARG, WDATA, SEND, DRAIN} state_t;
    typedef enum logic [1:0] {OP_SET, OP_CLR, OP_TGL} op_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [NOut-1:0]      out_q, out_d;
    logic                 err_q, err_d;
    logic [7:0]           errcnt_q, errcnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_send_q, tx_send_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [1:0]           qidx_q, qidx_d;
    logic [TimeoutW-1:0]  timer_q, timer_d;

    logic                 err_ev, cnt_ev, rep;
    logic [7:0]           rep_byte;
    logic [4:0]           hv;
    logic                 in_range;
    logic [NOut-1:0]      bit_mask;
    logic [SW-1:0]        wr_stage;

    // {valid, value}; accepts both letter cases
    function automatic logic [4:0] hex_dec(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, b[3:0]};
        else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46))
            r = {1'b1, b[3:0] + 4'd9};
        return r;
    endfunction

    function automatic logic [7:0] hex_enc(input logic [3:0] v);
        return (v < 4'd10) ? {4'h3, v} : (8'h57 + {4'h0, v});
    endfunction

    function automatic logic [3:0] nib_at(input logic [SW-1:0] s, input logic [1:0] i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < ND; k++)
            if (i == 2'(k)) r = s[4*k +: 4];
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= OP_SET;
            out_q     <= '0;
            err_q     <= 1'b0;
            errcnt_q  <= 8'h00;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
            stage_q   <= '0;
            cnt_q     <= 3'd0;
            qidx_q    <= 2'd0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            out_q     <= out_d;
            err_q     <= err_d;
            errcnt_q  <= errcnt_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            qidx_q    <= qidx_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        out_d     = out_q;
        err_d     = err_q;
        errcnt_d  = errcnt_q;
        tx_data_d = tx_data_q;
        tx_send_d = tx_send_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        qidx_d    = qidx_q;
        timer_d   = timer_q;
        err_ev    = 1'b0;
        cnt_ev    = 1'b0;
        rep       = 1'b0;
        rep_byte  = 8'h00;
        hv        = hex_dec(rx_data);
        in_range  = hv[4] && ({28'd0, hv[3:0]} < 32'(NOut));
        bit_mask  = NOut'(1) << hv[3:0];
        wr_stage  = (stage_q << 4) | SW'(hv[3:0]);

        case (state_q)
            IDLE: begin
                if (rx_err) begin
                    err_ev = 1'b1;
                end else if (rx_ready) begin
                    case (rx_data)
                        8'h71: begin
                            stage_d   = SW'(out_q);
                            qidx_d    = 2'(ND - 1);
                            tx_data_d = hex_enc(nib_at(SW'(out_q), 2'(ND - 1)));
                            tx_send_d = 1'b1;
                            state_d   = SEND;
                        end
                        8'h73, 8'h63, 8'h74: begin
                            op_d    = (rx_data == 8'h73) ? OP_SET :
                                      (rx_data == 8'h63) ? OP_CLR : OP_TGL;
                            timer_d = '0;
                            state_d = ARG;
                        end
                        8'h77: begin
                            stage_d = '0;
                            cnt_d   = 3'd0;
                            timer_d = '0;
                            state_d = WDATA;
                        end
                        8'h65: begin
                            err_d    = 1'b0;
                            errcnt_d = 8'h00;
                            rep      = 1'b1;
                            rep_byte = 8'h45;
                        end
                        default: err_ev = 1'b1;
                    endcase
                end
            end
            ARG: begin
                if (rx_err) begin
                    err_ev = 1'b1;
                end else if (rx_ready) begin
                    timer_d = '0;
                    if (in_range) begin
                        rep = 1'b1;
                        case (op_q)
                            OP_SET: begin out_d = out_q | bit_mask;  rep_byte = 8'h53; end
                            OP_CLR: begin out_d = out_q & ~bit_mask; rep_byte = 8'h43; end
                            default: begin out_d = out_q ^ bit_mask; rep_byte = 8'h54; end
                        endcase
                    end else begin
                        err_ev = 1'b1;
                    end
                end else if (&timer_q) begin
                    err_ev = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WDATA: begin
                if (rx_err) begin
                    err_ev = 1'b1;
                end else if (rx_ready) begin
                    timer_d = '0;
                    if (hv[4]) begin
                        stage_d = wr_stage;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'(ND - 1)) begin
                            out_d    = wr_stage[NOut-1:0];
                            rep      = 1'b1;
                            rep_byte = 8'h57;
                        end
                    end else begin
                        err_ev = 1'b1;
                    end
                end else if (&timer_q) begin
                    err_ev = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SEND: begin
                cnt_ev = rx_err;
                if (tx_busy) begin
                    tx_send_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                cnt_ev = rx_err;
                if (!tx_busy) begin
                    if (qidx_q != 2'd0) begin
                        qidx_d    = qidx_q - 2'd1;
                        tx_data_d = hex_enc(nib_at(stage_q, qidx_q - 2'd1));
                        tx_send_d = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_ev) begin
            rep      = 1'b1;
            rep_byte = 8'h3F;
        end
        if (err_ev || cnt_ev) begin
            err_d = 1'b1;
            if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
        end
        // single-byte replies leave qidx at zero so DRAIN returns to IDLE
        if (rep) begin
            tx_data_d = rep_byte;
            tx_send_d = 1'b1;
            qidx_d    = 2'd0;
            state_d   = SEND;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_send = tx_send_q;
    assign out     = out_q;
    assign err     = err_q;
    assign errcnt  = errcnt_q;
endmodule

// File: tb/tb_uart_reg_cmd.sv
// tb_uart_reg_cmd: directed plus randomized command stream against a
// command-level model of the output bank and error counter.
module tb_uart_reg_cmd;
    localparam int NOUT = 8;
    localparam int TW   = 8;
    localparam int BUSY = 20;
    localparam int ND   = (NOUT + 3) / 4;

    logic            clk;
    logic            reset_n;
    logic [7:0]      rx_data;
    logic            rx_ready;
    logic            rx_err;
    logic [7:0]      tx_data;
    logic            tx_send;
    logic            tx_busy;
    logic [NOUT-1:0] out;
    logic            err;
    logic [7:0]      errcnt;

    uart_reg_cmd #(.NOut(NOUT), .TimeoutW(TW)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_err(rx_err), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .out(out), .err(err), .errcnt(errcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart transmitter model: accepts a byte when idle, busy for BUSY cycles
    logic [7:0] cap_q[$];
    int         bcnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end else if (tx_send && !tx_busy) begin
            tx_busy <= 1'b1;
            bcnt    <= BUSY;
            cap_q.push_back(tx_data);
        end
    end

    int   pulses = 0;
    logic send_prev = 1'b0;
    always @(posedge clk) begin
        send_prev <= tx_send;
        if (tx_send && !send_prev) pulses <= pulses + 1;
    end

    int         checks = 0;
    int         failures = 0;
    int         cap_base = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_out;
    logic       m_err;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] hexc(input int v);
        string h;
        h = "0123456789abcdef";
        return h[v];
    endfunction

    function automatic int hval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - int'("0");
        if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
        if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
        return -1;
    endfunction

    function automatic logic [7:0] rand_arg();
        string hs, bs;
        hs = "0123456789abcdefABCDEF";
        bs = "xg/:@G z";
        if ($urandom_range(0, 9) < 8) return hs[$urandom_range(0, 21)];
        return bs[$urandom_range(0, 7)];
    endfunction

    task automatic model_err();
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_replies(input string tag);
        int n, t;
        logic [31:0] got;
        n = exp_q.size();
        t = 0;
        while ((cap_q.size() < cap_base + n || tx_busy || tx_send) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_nreply"}, 32'(cap_q.size() - cap_base), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (cap_base + i < cap_q.size()) ? {24'd0, cap_q[cap_base + i]} : 32'hxxxxxxxx;
            check({tag, "_reply"}, got, {24'd0, exp_q[i]});
        end
        cap_base = cap_q.size();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_out"}, 32'(out), 32'(m_out));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_errcnt"}, 32'(errcnt), 32'(m_cnt));
    endtask

    task automatic check_latency(input string tag);
        check({tag, "_lat"}, 32'(tx_send), 32'd1);
        check({tag, "_outlat"}, 32'(out), 32'(m_out));
    endtask

    task automatic cmd_query(input string tag);
        for (int d = ND - 1; d >= 0; d--) exp_q.push_back(hexc((int'(m_out) >> (4 * d)) & 15));
        send_byte("q");
        check_latency(tag);
        wait_replies(tag);
        check_state(tag);
    endtask

    task automatic cmd_bit(input logic [7:0] op, input logic [7:0] arg, input string tag);
        int v;
        v = hval(arg);
        if (v >= 0 && v < NOUT) begin
            if (op == "s") begin m_out = m_out | (8'd1 << v);  exp_q.push_back("S"); end
            if (op == "c") begin m_out = m_out & ~(8'd1 << v); exp_q.push_back("C"); end
            if (op == "t") begin m_out = m_out ^ (8'd1 << v);  exp_q.push_back("T"); end
        end else begin
            model_err();
            exp_q.push_back("?");
        end
        send_byte(op);
        send_byte(arg);
        check_latency(tag);
        wait_replies(tag);
        check_state(tag);
    endtask

    task automatic cmd_write(input logic [7:0] c1, input logic [7:0] c2, input string tag);
        int v1, v2;
        v1 = hval(c1);
        v2 = hval(c2);
        send_byte("w");
        if (v1 < 0) begin
            model_err();
            exp_q.push_back("?");
            send_byte(c1);
        end else begin
            if (v2 < 0) begin
                model_err();
                exp_q.push_back("?");
            end else begin
                m_out = 8'((v1 * 16 + v2) % 256);
                exp_q.push_back("W");
            end
            send_byte(c1);
            send_byte(c2);
        end
        check_latency(tag);
        wait_replies(tag);
        check_state(tag);
    endtask

    task automatic cmd_clear(input string tag);
        m_err = 1'b0;
        m_cnt = 0;
        exp_q.push_back("E");
        send_byte("e");
        check_latency(tag);
        wait_replies(tag);
        check_state(tag);
    endtask

    task automatic cmd_bad(input logic [7:0] b, input string tag);
        model_err();
        exp_q.push_back("?");
        send_byte(b);
        check_latency(tag);
        wait_replies(tag);
        check_state(tag);
    endtask

    initial begin
        string bad;
        int    p0, t, k;
        bad      = "xzQ1?S#r";
        reset_n  = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        rx_err   = 1'b0;
        m_out    = 8'h00;
        m_err    = 1'b0;
        m_cnt    = 0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        check("reset_tx_send", 32'(tx_send), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        reset_n = 1'b1;

        p0 = pulses;
        cmd_query("q0");
        check("q0_pulses", 32'(pulses - p0), 32'(ND));

        cmd_bit("s", "3", "s3");
        cmd_bit("t", "3", "t3");
        cmd_bit("c", "0", "c0");
        cmd_write("A", "5", "wa5");
        cmd_query("qa5");
        cmd_bit("t", "9", "t9");
        cmd_bad("x", "badx");

        // argument timeout
        cmd_clear("clr1");
        send_byte("s");
        repeat (248) @(posedge clk);
        #1;
        check("to_early", 32'(tx_send), 32'd0);
        t = 0;
        while (!tx_send && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        check("to_fire", 32'(tx_send), 32'd1);
        model_err();
        exp_q.push_back("?");
        wait_replies("to");
        check_state("to");
        cmd_bad("1", "to_next");

        // framing error in the middle of a write
        send_byte("w");
        send_byte("A");
        @(posedge clk); #1;
        rx_err = 1'b1;
        @(posedge clk); #1;
        rx_err = 1'b0;
        model_err();
        exp_q.push_back("?");
        check_latency("rxerr");
        wait_replies("rxerr");
        check_state("rxerr");
        cmd_clear("clr2");

        // reset while a reply is pending
        send_byte("q");
        check("rst_pre", 32'(tx_send), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        m_out = 8'h00;
        m_err = 1'b0;
        m_cnt = 0;
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check_state("rst");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        cap_base = cap_q.size();
        cmd_query("q_after_rst");

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: cmd_bit("s", rand_arg(), "rnd_s");
                1: cmd_bit("c", rand_arg(), "rnd_c");
                2: cmd_bit("t", rand_arg(), "rnd_t");
                3: cmd_write(rand_arg(), rand_arg(), "rnd_w");
                4: cmd_query("rnd_q");
                default: if ($urandom_range(0, 3) == 0) cmd_clear("rnd_e");
                         else cmd_bad(bad[$urandom_range(0, 7)], "rnd_bad");
            endcase
        end

        // saturation
        cmd_clear("clr3");
        for (int i = 0; i < 300; i++) cmd_bad("x", "sat");
        check("sat_final", 32'(errcnt), 32'hFF);

        // simultaneous rx_ready and rx_err: error wins, 'e' ignored
        @(posedge clk); #1;
        rx_data  = "e";
        rx_ready = 1'b1;
        rx_err   = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        rx_err   = 1'b0;
        model_err();
        exp_q.push_back("?");
        wait_replies("both");
        check_state("both");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
